// File: rtl/grant_decoder.sv
// Registered one-hot grant issuer fed by a priority encoder's {index, valid}.
// Optional grant expiry is compiled in with GRANT_DECODER_TIMEOUT_EN.
module grant_decoder #(
  parameter int IDX_W    = 2,
  parameter int N        = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     ack,
  output logic [N-1:0]     grant,
  output logic [7:0]       done_cnt,
  output logic             timeout,
  output logic             spurious
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE_HOT_BASE = {{(N-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [N-1:0]     grant_nx;
  logic [7:0]       done_nx;
  logic             timeout_nx;
  logic             spurious_nx;
  logic             ack_hit;

`ifdef GRANT_DECODER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt, hold_nx;
`else
  logic [7:0] unused_hold_max;
  assign unused_hold_max = 8'(HOLD_MAX);
`endif

  assign in_ready = (state == IDLE);
  assign ack_hit  = ack[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      grant    <= '0;
      done_cnt <= '0;
      timeout  <= 1'b0;
      spurious <= 1'b0;
`ifdef GRANT_DECODER_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      grant    <= grant_nx;
      done_cnt <= done_nx;
      timeout  <= timeout_nx;
      spurious <= spurious_nx;
`ifdef GRANT_DECODER_TIMEOUT_EN
      hold_cnt <= hold_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    grant_nx    = grant;
    done_nx     = done_cnt;
    timeout_nx  = 1'b0;
    spurious_nx = 1'b0;
`ifdef GRANT_DECODER_TIMEOUT_EN
    hold_nx     = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          idx_nx   = in_idx;
          grant_nx = ONE_HOT_BASE << in_idx;
          state_nx = GRANT;
`ifdef GRANT_DECODER_TIMEOUT_EN
          hold_nx  = '0;
`endif
        end
      end
      GRANT: begin
        // grant is one-hot on idx here, so its complement masks the other lines
        spurious_nx = |(ack & ~grant);
        if (ack_hit) begin
          grant_nx = '0;
          done_nx  = done_cnt + 8'd1;
          state_nx = RELEASE;
        end
`ifdef GRANT_DECODER_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          grant_nx   = '0;
          timeout_nx = 1'b1;
          state_nx   = RELEASE;
        end else begin
          hold_nx = hold_cnt + 8'd1;
        end
`endif
      end
      RELEASE: begin
        grant_nx = '0;
        // waiting for ack to fall keeps one long ack level from completing twice
        if (ack == '0) state_nx = IDLE;
      end
      default: begin
        grant_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_grant_decoder.sv
// Directed self-checking bench for grant_decoder; the timeout scenario runs
// when GRANT_DECODER_TIMEOUT_EN is defined, the no-expiry scenario otherwise.
module tb_grant_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in_idx = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] ack = '0;
  logic [3:0] grant;
  logic [7:0] done_cnt;
  logic       timeout;
  logic       spurious;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_done = '0;

  grant_decoder #(.IDX_W(2), .N(4), .HOLD_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_idx(in_idx), .in_valid(in_valid),
    .in_ready(in_ready), .ack(ack), .grant(grant), .done_cnt(done_cnt),
    .timeout(timeout), .spurious(spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; ack = '0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b required 1", in_ready); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b required 0000", grant); end
    checks++; if (done_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_done: got %0d required 0", done_cnt); end
    checks++; if ({timeout, spurious} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b required 00", {timeout, spurious}); end
    tick();
    rst_n = 1'b1;
    exp_done = '0;
    tick();
  endtask

  task automatic test_single_grant();
    in_idx = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant_t1: got %b required 0100", grant); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_busy: got %b required 0", in_ready); end
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant_hold: got %b required 0100", grant); end
    ack = 4'b0100;
    tick();
    exp_done = exp_done + 8'd1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL single_grant_clear: got %b required 0000", grant); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL single_done: got %0d required %0d", done_cnt, exp_done); end
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_release_hold: got %b required 0", in_ready); end
    ack = '0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_back: got %b required 1", in_ready); end
  endtask

  task automatic test_held_ack();
    in_idx = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ack = 4'b0010;
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL held_grant: got %b required 0010", grant); end
    tick();
    exp_done = exp_done + 8'd1;
    in_idx = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL held_done_%0d: got %0d required %0d", i, done_cnt, exp_done); end
      checks++; if ({in_ready, grant} !== 5'b0_0000) begin errors++; $display("[TB] FAIL held_blocked_%0d: got ready=%b grant=%b required ready=0 grant=0000", i, in_ready, grant); end
      tick();
    end
    ack = '0;
    tick();
    in_valid = 1'b0;
    checks++; if ({in_ready, grant} !== 5'b1_0000) begin errors++; $display("[TB] FAIL held_not_accepted: got ready=%b grant=%b required ready=1 grant=0000", in_ready, grant); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL held_single_completion: got %0d required %0d", done_cnt, exp_done); end
  endtask

  task automatic test_spurious();
    in_idx = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL spur_grant: got %b required 0001", grant); end
    ack = 4'b1001;
    tick();
    exp_done = exp_done + 8'd1;
    ack = '0;
    checks++; if (spurious !== 1'b1) begin errors++; $display("[TB] FAIL spur_pulse: got %b required 1", spurious); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL spur_complete: got %b required 0000", grant); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL spur_done: got %0d required %0d", done_cnt, exp_done); end
    tick();
    checks++; if (spurious !== 1'b0) begin errors++; $display("[TB] FAIL spur_one_cycle: got %b required 0", spurious); end
    // spurious bit alone leaves the grant in place
    in_idx = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ack = 4'b0001;
    tick();
    ack = '0;
    checks++; if ({spurious, grant} !== 5'b1_0100) begin errors++; $display("[TB] FAIL spur_only: got spurious=%b grant=%b required spurious=1 grant=0100", spurious, grant); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL spur_only_done: got %0d required %0d", done_cnt, exp_done); end
    ack = 4'b0100;
    tick();
    exp_done = exp_done + 8'd1;
    ack = '0;
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL spur_only_finish: got %0d required %0d", done_cnt, exp_done); end
    tick();
  endtask

`ifdef GRANT_DECODER_TIMEOUT_EN
  task automatic test_timeout();
    in_idx = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      checks++; if ({grant, timeout} !== 5'b1000_0) begin errors++; $display("[TB] FAIL to_hold_cycle%0d: got grant=%b timeout=%b required grant=1000 timeout=0", c, grant, timeout); end
      if (c < 15) tick();
    end
    tick();
    checks++; if ({grant, timeout} !== 5'b0000_1) begin errors++; $display("[TB] FAIL to_expire: got grant=%b timeout=%b required grant=0000 timeout=1", grant, timeout); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL to_done_same: got %0d required %0d", done_cnt, exp_done); end
    tick();
    checks++; if ({in_ready, timeout} !== 2'b10) begin errors++; $display("[TB] FAIL to_recover: got ready=%b timeout=%b required ready=1 timeout=0", in_ready, timeout); end
    in_idx = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL to_race_grant: got %b required 1000", grant); end
    ack = 4'b1000;
    tick();
    exp_done = exp_done + 8'd1;
    ack = '0;
    checks++; if ({grant, timeout} !== 5'b0000_0) begin errors++; $display("[TB] FAIL to_race_ack_wins: got grant=%b timeout=%b required grant=0000 timeout=0", grant, timeout); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL to_race_done: got %0d required %0d", done_cnt, exp_done); end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    bad = 0;
    in_idx = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if ({grant, timeout} !== 5'b1000_0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL no_to_hold: got %0d bad cycles required 0", bad); end
    checks++; if ({grant, timeout} !== 5'b1000_0) begin errors++; $display("[TB] FAIL no_to_end: got grant=%b timeout=%b required grant=1000 timeout=0", grant, timeout); end
    ack = 4'b1000;
    tick();
    exp_done = exp_done + 8'd1;
    ack = '0;
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL no_to_done: got %0d required %0d", done_cnt, exp_done); end
    tick();
  endtask
`endif

  task automatic test_async_reset();
    in_idx = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL arst_pre: got %b required 0010", grant); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_done = '0;
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL arst_grant: got %b required 0000", grant); end
    checks++; if (done_cnt !== 8'd0) begin errors++; $display("[TB] FAIL arst_done: got %0d required 0", done_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_ready: got %b required 1", in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    for (int g = 0; g < 256; g++) begin
      in_idx = 2'(g); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      ack = 4'b0001 << (g % 4);
      tick();
      exp_done = exp_done + 8'd1;
      ack = '0;
      if (g == 254) begin
        checks++; if (done_cnt !== 8'd255) begin errors++; $display("[TB] FAIL wrap_255: got %0d required 255", done_cnt); end
      end
      tick();
    end
    checks++; if (done_cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_zero: got %0d required 0", done_cnt); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("[TB] FAIL wrap_model: got %0d required %0d", done_cnt, exp_done); end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_held_ack();
    test_spurious();
`ifdef GRANT_DECODER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_decoder.md
# grant_decoder

Sequential consumer for the 4-to-2 priority encoder's `{index, valid}` output. Accepts an encoded index through a valid/ready handshake, decodes it to a registered one-hot grant, and holds that grant until the addressed channel acknowledges it. An optional timeout prevents a dead channel from stalling the block. It sits between the encoder and the per-channel service logic.

## Interface
- `IDX_W`, default 2: encoded index width.
- `N`, default 4: number of channels; must equal 2**IDX_W.
- `HOLD_MAX`, default 15: maximum grant cycles before timeout; valid range 1..255.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_idx`  in  IDX_W  encoded channel index (encoder `out`).
- `in_valid`  in  1  index valid (encoder `valid`).
- `in_ready`  out  1  block can accept an index.
- `ack`  in  N  per-channel acknowledge; level-sensitive.
- `grant`  out  N  one-hot grant, registered.
- `done_cnt`  out  8  completed (acknowledged) grants; wraps 255 -> 0.
- `timeout`  out  1  one-cycle pulse when a grant expires.
- `spurious`  out  1  one-cycle pulse when a non-granted ack bit is seen in GRANT.

## Operation
- States: IDLE, GRANT, RELEASE. Encoding is free.
- `in_ready` = (state == IDLE). It is combinational from state only and never depends on `in_valid`.
- Transfer occurs when `in_valid && in_ready` at a rising edge.
- IDLE: on transfer, latch `in_idx`, set `grant` <= 1 << `in_idx`, clear the hold counter, and go to GRANT. `in_idx` is ignored when `in_valid` = 0.
- GRANT: `grant` holds exactly one bit. Each edge samples `ack[idx]`:
  - If set: clear `grant`, increment `done_cnt`, go to RELEASE.
  - Otherwise: increment the hold counter.
  - When the counter reaches HOLD_MAX-1 with no ack (timeout enabled only): clear `grant`, assert `timeout` for the next cycle, go to RELEASE. `done_cnt` is unchanged.
- An ack on the granted line in the same cycle as expiry wins: no timeout, and `done_cnt` increments.
- Spurious ack: any `ack` bit other than `idx` set during a GRANT cycle registers `spurious` = 1 for one cycle. The bit is otherwise ignored. It can coincide with a valid completion, in which case both take effect.
- RELEASE: `grant` = 0 and `in_ready` = 0. Stay while `|ack`; go to IDLE on the first edge where `ack` == 0. This guarantees one ack level never completes two grants.
- `ack` bits are not examined in IDLE.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state = IDLE, so `in_ready` = 1 while `rst_n` is low.
  - `grant` = 0, `done_cnt` = 0, `timeout` = 0, `spurious` = 0.
- Reset mid-GRANT drops `grant` in the same instant, without waiting for a clock edge.
- Latency:
  - Transfer edge T: `grant` visible from T+1.
  - Earliest ack sample at edge T+1 (ack already high), giving `grant` low from T+2.
  - RELEASE lasts at least one cycle, so `in_ready` returns at T+3 at the earliest.
  - Minimum back-to-back acceptance period is 3 cycles.
- With the timeout path, `grant` is high for exactly HOLD_MAX cycles. `timeout` is high in the first cycle `grant` is low.
- `done_cnt` updates on the same edge that clears `grant`.
- `grant` is glitch-free and never carries more than one set bit.

## Configuration
- `GRANT_DECODER_TIMEOUT_EN` defined: hold counter (8 bit) and expiry path are present as described.
- Not defined:
  - No counter is built, and `grant` is held indefinitely until acked.
  - `timeout` is tied to 0, and `HOLD_MAX` is ignored.
- All other behaviour is identical in both builds.

## Test plan
- Reset then single grant: release reset, drive `in_idx`=2 and `in_valid`=1 for one cycle, then `ack`=4'b0100 two cycles later.
  - `grant`=4'b0100 from T+1.
  - `grant` clears after the ack edge, and `done_cnt`=1.
  - `in_ready` returns only after `ack`=0.
- Held ack: keep `ack[1]`=1 for 5 cycles after a grant on index 1.
  - Exactly one completion (`done_cnt` +1).
  - `in_ready` stays 0 until ack drops.
  - A second `in_valid` offered meanwhile is not accepted.
- Spurious plus valid: grant index 0, then drive `ack`=4'b1001 in one cycle.
  - `spurious` pulses once.
  - Grant completes, and `done_cnt` increments.
- Timeout (macro defined, HOLD_MAX=15): grant index 3 with no ack.
  - `grant`=4'b1000 for exactly 15 cycles.
  - `timeout` pulses on the 16th cycle, and `done_cnt` is unchanged.
  - Repeat with the ack arriving in cycle 15: no timeout, and the count increments.
- Macro undefined: grant with no ack for 300 cycles.
  - `grant` remains set and `timeout` stays 0.
- Async reset mid-grant: assert `rst_n`=0 between clock edges during GRANT.
  - `grant`=0 immediately and `done_cnt`=0.
  - `in_ready`=1.
- Counter wrap: run 256 completed grants, and `done_cnt` reads 0.
